muldiv_sequencer: RTL



---
 rtl/muldiv_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: 32-step shift-add multiplier and
// restoring divider behind a valid/ready start handshake.
module muldiv_sequencer #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            kill,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            stall
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;

    logic              accept, is_div, sgn1, sgn2, n1, n2;
    logic              div_zero, ovf, special, last, ge;
    logic [XLEN-1:0]   abs1, abs2, spec_res, quo, rem, fin;
    logic [XLEN:0]     sum, shifted;
    logic [2*XLEN-1:0] step, prod;

    always_comb begin
        accept   = start_valid & (state_q == IDLE) & ~kill;
        is_div   = op[2];
        sgn1     = (op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6);
        sgn2     = (op == 3'd1) | (op == 3'd4) | (op == 3'd6);
        n1       = sgn1 & operand1[XLEN-1];
        n2       = sgn2 & operand2[XLEN-1];
        abs1     = n1 ? -operand1 : operand1;
        abs2     = n2 ? -operand2 : operand2;
        div_zero = is_div & (operand2 == '0);
        ovf      = ((op == 3'd4) | (op == 3'd6))
                 & (operand1 == {1'b1, {(XLEN-1){1'b0}}})
                 & (operand2 == '1);
        special  = div_zero | ovf;
        // Overflowed DIV happens to return the dividend itself.
        if (div_zero) spec_res = op[1] ? operand1 : '1;
        else          spec_res = op[1] ? '0 : operand1;
        last     = (cnt_q == 6'(ITER - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    always_comb begin
        start_ready  = (state_q == IDLE);
        busy         = (state_q != IDLE);
        result_valid = (state_q == DONE) & ~kill;
        stall        = (start_valid & (state_q == IDLE)) | (state_q == CALC);
        result       = result_q;
    end

    // Both engines share acc: multiplier or dividend/quotient in the low
    // half, product high half or partial remainder in the upper half.
    always_comb begin
        sum     = {1'b0, acc_q[2*XLEN-1:XLEN]}
                + (acc_q[0] ? {1'b0, a_q} : '0);
        shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        ge      = (shifted >= {1'b0, a_q});
        if (!op_q[2])
            step = {sum, acc_q[XLEN-1:1]};
        else if (ge)
            step = {shifted[XLEN-1:0] - a_q, acc_q[XLEN-2:0], 1'b1};
        else
            step = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        prod = neg_q ? -step : step;
        quo  = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem  = rneg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        fin  = prod[2*XLEN-1:XLEN];
        unique case (1'b1)
            op_q[2] & op_q[1]:            fin = rem;
            op_q[2] & ~op_q[1]:           fin = quo;
            ~op_q[2] & (op_q[1:0] == 0):  fin = prod[XLEN-1:0];
            ~op_q[2] & (op_q[1:0] != 0):  fin = prod[2*XLEN-1:XLEN];
            default:                      fin = prod[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        if (accept) begin
            op_d   = op;
            cnt_d  = '0;
            neg_d  = n1 ^ n2;
            rneg_d = n1;
            a_d    = is_div ? abs2 : abs1;
            acc_d  = {{XLEN{1'b0}}, is_div ? abs1 : abs2};
            if (special) result_d = spec_res;
        end else if (state_q == CALC) begin
            acc_d = step;
            cnt_d = cnt_q + 6'd1;
            if (last & ~kill) result_d = fin;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

endmodule
